// File: rtl/yuv_rgb_pkg.sv
// Shared types and constants for the YUV 4:2:2 to RGB conversion stage.
// Fixed-point coefficients are the BT.601 factors scaled by 2^16.
package yuv_rgb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  localparam logic signed [31:0] COEF_Y  = 32'sd76284;
  localparam logic signed [31:0] COEF_RV = 32'sd104595;
  localparam logic signed [31:0] COEF_GU = 32'sd25624;
  localparam logic signed [31:0] COEF_GV = 32'sd53281;
  localparam logic signed [31:0] COEF_BU = 32'sd132251;

  localparam logic signed [31:0] Y_OFFSET = 32'sd16;
  localparam logic signed [31:0] C_OFFSET = 32'sd128;

  localparam logic [17:0] DEF_Y_BASE   = 18'd0;
  localparam logic [17:0] DEF_U_BASE   = 18'd38400;
  localparam logic [17:0] DEF_V_BASE   = 18'd57600;
  localparam logic [17:0] DEF_RGB_BASE = 18'd146944;
  localparam int          DEF_NUM_GROUPS = 19200;

  // Drop the 16 fractional bits, then saturate to an unsigned byte.
  function automatic logic [7:0] clip_shift16(input logic signed [31:0] acc);
    logic signed [31:0] q;
    q = acc >>> 16;
    if (q < 32'sd0)
      return 8'd0;
    else if (q > 32'sd255)
      return 8'd255;
    else
      return q[7:0];
  endfunction

endpackage

// File: rtl/csc_pixel.sv
// Combinational colour-space conversion of one Y/U/V byte triple into
// clipped R/G/B bytes; the parent registers the result.
module csc_pixel
  import yuv_rgb_pkg::*;
(
  input  logic [7:0] y,
  input  logic [7:0] u,
  input  logic [7:0] v,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b
);

  logic signed [31:0] e_s;
  logic signed [31:0] u_s;
  logic signed [31:0] v_s;
  logic signed [31:0] acc_r;
  logic signed [31:0] acc_g;
  logic signed [31:0] acc_b;

  always_comb begin
    e_s   = $signed({24'd0, y}) - Y_OFFSET;
    u_s   = $signed({24'd0, u}) - C_OFFSET;
    v_s   = $signed({24'd0, v}) - C_OFFSET;
    acc_r = COEF_Y * e_s + COEF_RV * v_s;
    acc_g = COEF_Y * e_s - COEF_GU * u_s - COEF_GV * v_s;
    acc_b = COEF_Y * e_s + COEF_BU * u_s;
  end

  assign r = clip_shift16(acc_r);
  assign g = clip_shift16(acc_g);
  assign b = clip_shift16(acc_b);

endmodule

// File: rtl/yuv_rgb_converter.sv
// Milestone-1 colour-space converter: reads Y/U/V 4:2:2 from SRAM in 4-pixel
// groups, converts with replicated chroma, writes packed RGB back, pulses done.
module yuv_rgb_converter
  import yuv_rgb_pkg::*;
#(
  parameter logic [17:0] Y_BASE     = DEF_Y_BASE,
  parameter logic [17:0] U_BASE     = DEF_U_BASE,
  parameter logic [17:0] V_BASE     = DEF_V_BASE,
  parameter logic [17:0] RGB_BASE   = DEF_RGB_BASE,
  parameter int          NUM_GROUPS = DEF_NUM_GROUPS
) (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        start,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic        done
);

  localparam logic [17:0] LAST_K = 18'(NUM_GROUPS - 1);

  state_t      state, state_n;
  logic [3:0]  cyc, cyc_n;
  logic [17:0] k, k_n;
  logic [17:0] addr_n;
  logic [15:0] wdata_n;
  logic        we_n_n;
  logic        done_n;

  logic [15:0] y01, y23, u02, v02;
  logic [7:0]  rgb_bytes [12];

  logic [1:0]  pix;
  logic [3:0]  pix_base;
  logic [7:0]  px_y, px_u, px_v;
  logic [7:0]  px_r, px_g, px_b;

  logic [2:0]  wr_idx;
  logic [3:0]  byte_idx;
  logic [17:0] grp_rgb_base;

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state           <= S_IDLE;
      cyc             <= 4'd0;
      k               <= 18'd0;
      SRAM_address    <= 18'd0;
      SRAM_write_data <= 16'd0;
      SRAM_we_n       <= 1'b1;
      done            <= 1'b0;
    end else begin
      state           <= state_n;
      cyc             <= cyc_n;
      k               <= k_n;
      SRAM_address    <= addr_n;
      SRAM_write_data <= wdata_n;
      SRAM_we_n       <= we_n_n;
      done            <= done_n;
    end
  end

  // The six output words are consecutive byte pairs of R0 G0 B0 R1 ... B3.
  always_comb begin
    state_n      = state;
    cyc_n        = cyc;
    k_n          = k;
    addr_n       = SRAM_address;
    wdata_n      = SRAM_write_data;
    we_n_n       = 1'b1;
    done_n       = 1'b0;
    wr_idx       = 3'(cyc - 4'd10);
    byte_idx     = {wr_idx, 1'b0};
    grp_rgb_base = RGB_BASE + k * 18'd6;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          cyc_n   = 4'd0;
          k_n     = 18'd0;
        end
      end
      S_RUN: begin
        cyc_n = cyc + 4'd1;
        case (cyc)
          4'd0: addr_n = Y_BASE + (k << 1);
          4'd1: addr_n = Y_BASE + (k << 1) + 18'd1;
          4'd2: addr_n = U_BASE + k;
          4'd3: addr_n = V_BASE + k;
          4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: begin
            we_n_n  = 1'b0;
            addr_n  = grp_rgb_base + {15'd0, wr_idx};
            wdata_n = {rgb_bytes[byte_idx], rgb_bytes[byte_idx + 4'd1]};
          end
          default: ;
        endcase
        if (cyc == 4'd15) begin
          if (k == LAST_K) begin
            state_n = S_DONE;
            k_n     = 18'd0;
          end else begin
            k_n = k + 18'd1;
          end
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!start)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pixels 0/1 use the high chroma bytes, pixels 2/3 the low ones.
  always_comb begin
    pix      = 2'(cyc - 4'd6);
    pix_base = {2'd0, pix} + {1'b0, pix, 1'b0};
    px_y     = pix[0] ? (pix[1] ? y23[7:0]  : y01[7:0])
                      : (pix[1] ? y23[15:8] : y01[15:8]);
    px_u     = pix[1] ? u02[7:0] : u02[15:8];
    px_v     = pix[1] ? v02[7:0] : v02[15:8];
  end

  csc_pixel u_csc (
    .y (px_y),
    .u (px_u),
    .v (px_v),
    .r (px_r),
    .g (px_g),
    .b (px_b)
  );

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      y01 <= 16'd0;
      y23 <= 16'd0;
      u02 <= 16'd0;
      v02 <= 16'd0;
      for (int i = 0; i < 12; i++)
        rgb_bytes[i] <= 8'd0;
    end else if (state == S_RUN) begin
      case (cyc)
        4'd2: y01 <= SRAM_read_data;
        4'd3: y23 <= SRAM_read_data;
        4'd4: u02 <= SRAM_read_data;
        4'd5: v02 <= SRAM_read_data;
        4'd6, 4'd7, 4'd8, 4'd9: begin
          rgb_bytes[pix_base]         <= px_r;
          rgb_bytes[pix_base + 4'd1]  <= px_g;
          rgb_bytes[pix_base + 4'd2]  <= px_b;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/yuv_rgb_converter.md
Name: yuv_rgb_converter

Overview:
- Colour-space conversion stage that occupies the SRAM-owning milestone-1 slot between UART load and VGA display.
- On `start`, it reads Y/U/V 4:2:2 segments from external SRAM and converts them to RGB with zero-order-hold (replicated) chroma. It writes packed 24-bit RGB back to the RGB segment, then pulses `done`.
- It owns the SRAM address, write-data and we_n lines for the whole run.

Parameters:
- Y_BASE, 18'd0, word address of Y segment (word = {Y_even, Y_odd})
- U_BASE, 18'd38400, word address of U segment (word = {U_p0, U_p2} per 4 pixels)
- V_BASE, 18'd57600, word address of V segment (same packing as U)
- RGB_BASE, 18'd146944, word address of RGB output segment
- NUM_GROUPS, 19200, number of 4-pixel groups (320x240/4)

Ports:
- CLOCK_50_I  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  level request from top FSM; sampled only in S_IDLE
- SRAM_address  out  18  SRAM word address
- SRAM_read_data  in  16  SRAM read data, valid 2 cycles after the address cycle
- SRAM_write_data  out  16  SRAM write data
- SRAM_we_n  out  1  active-low write enable
- done  out  1  one-cycle pulse after the final write

Behaviour:
- Interface: one clock (CLOCK_50_I); reset is synchronous and active-high.
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, done=0. The group counter k=0 and the FSM enters S_IDLE.
- Reset mid-run: abandons the run at the next edge. we_n=1 from that edge onward, and no further writes occur.
- S_IDLE: we_n=1. start=1 moves to S_RUN with k=0.
- S_RUN, 16 cycles per group, cycle index c=0..15, all outputs registered:
  - c0..c3: SRAM_address = Y_BASE+2k, Y_BASE+2k+1, U_BASE+k, V_BASE+k; we_n=1.
  - c2..c5: capture SRAM_read_data as Y01, Y23, U02, V02.
  - c6..c9: compute pixel p=0..3, one per cycle, into RGB registers.
  - Chroma for p0,p1 = high bytes of U02/V02; for p2,p3 = low bytes.
  - c10..c15: we_n=0 with SRAM_address = RGB_BASE+6k+0..5.
  - Write data in order: {R0,G0}, {B0,R1}, {G1,B1}, {R2,G2}, {B2,R3}, {G3,B3}.
- Group step: after c15, k increments. If k == NUM_GROUPS-1 the FSM goes to S_DONE; otherwise c wraps to 0.
- S_DONE: done=1 for one cycle, we_n=1, then go to S_WAIT_LOW.
- S_WAIT_LOW: stays until start=0, then goes to S_IDLE. This prevents an immediate re-run while the top holds start high.
- Run length: start is sampled in S_IDLE at edge T. The first address appears at T+1, and done=1 at T+1+16*NUM_GROUPS.
- start changes during S_RUN are ignored.
- CSC arithmetic, signed 32-bit, per pixel:
  - e = Y-16, u = U-128, v = V-128
  - R = 76284e + 104595v
  - G = 76284e - 25624u - 53281v
  - B = 76284e + 132251u
- Result = arithmetic >>16, then clip: negative → 0, >255 → 255, else the low 8 bits.
- SRAM_write_data holds its last value whenever we_n=1 (don't-care, but deterministic).

Decomposition:
- Package yuv_rgb_pkg holds:
  - state enum (S_IDLE, S_RUN, S_DONE, S_WAIT_LOW)
  - coefficients (76284, 104595, 25624, 53281, 132251) and offsets (16, 128)
  - the default segment base constants
- Sub-module csc_pixel:
  - inputs: Y, U, V bytes
  - outputs: clipped R, G, B bytes
  - purely combinational; the parent registers its outputs at c6..c9.

Test Plan:
- All Y words 0x1010, U/V words 0x8080, NUM_GROUPS=2 → 12 writes at RGB_BASE..+11, all data 0x0000. done pulses exactly 33 cycles after the start-sampled edge.
- Y=0xEBEB, U=V=0x8080 → each pixel R=G=B=0xFE; words 0xFEFE repeated.
- Y=0xFFFF, U=0x8080, V=0xFFFF → R clips to 0xFF (raw 480). Y=0x0000, V=0x0000 → R clips to 0x00 (negative).
- Chroma replication: U02=0xFF00, V02=0x8080, Y=0x8080:
  - p0,p1 take B = (76284*112 + 132251*127)>>16 = 386 → 0xFF
  - p2,p3 take B = (76284*112 - 132251*128)>>16 < 0 → 0x00
- Address sequence check for k=0..2: read order Y,Y,U,V, then 6 writes at RGB_BASE+6k. we_n is low only at c10..c15.
- Reset asserted at group 1, c12 → we_n=1 from the next edge, state S_IDLE, no done. A new start restarts at k=0.
- start held high after done → no second run until start goes 0 then 1.
